wb_pipe_skid_reg: RTL
=====================

Name: wb_pipe_skid_reg

Overview:
- Parametrised MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Lets the write-back stage stall without a combinational ready path back into MEM.
- Supports synchronous flush.
- Adds a pre-muxed write-back value so WB sees one data bus.

Parameters:
- DATA_W, 32, width of ALU_Res / MEM_Result payloads
- DEST_W, 4, width of destination register index

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush; drops all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  block can accept an entry this cycle
- WB_EN  in  1  write-back enable of incoming entry
- MEM_R_EN  in  1  memory-read flag of incoming entry
- ALU_Res  in  DATA_W  ALU result
- MEM_Result  in  DATA_W  memory read data
- Dest  in  DEST_W  destination register index
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream consumes entry this cycle
- WB_EN_out  out  1  write-back enable of head entry, forced 0 when out_valid=0
- MEM_R_EN_out  out  1  memory-read flag of head entry
- ALU_Res_out  out  DATA_W  head ALU result
- MEM_Result_out  out  DATA_W  head memory data
- Dest_out  out  DEST_W  head destination index
- wb_value_out  out  DATA_W  MEM_R_EN_out ? MEM_Result_out : ALU_Res_out

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, sampled on the clk rising edge. Priority order: rst > flush > handshake.
- Storage: main register (drives outputs) plus skid register. State is EMPTY / BUSY (main only) / FULL (main+skid).
- Handshake signals:
  - in_ready = (state != FULL) && !rst, decoded from state only; no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - acc = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions:
  - EMPTY: acc -> BUSY, main<=in; else stay.
  - BUSY: acc & !pop -> FULL, skid<=in. !acc & pop -> EMPTY. acc & pop -> BUSY, main<=in. Neither: hold.
  - FULL: pop -> BUSY, main<=skid. acc impossible (in_ready=0).
- Latency: entry accepted at edge N is visible on the outputs after edge N; 1-cycle latency when empty.
- Ordering: FIFO order strictly preserved; no entry lost or duplicated.
- Stability: while out_valid=1 and out_ready=0, all *_out and wb_value_out hold constant.
- Reset: state=EMPTY; all payload registers cleared.
  - WB_EN_out=0, MEM_R_EN_out=0, ALU_Res_out=0, MEM_Result_out=0, Dest_out=0, wb_value_out=0, out_valid=0.
  - in_ready=0 while rst is high; 1 the cycle after rst deasserts.
- Flush: state<=EMPTY; main and skid WB_EN/MEM_R_EN cleared; data fields may hold.
  - An input presented in the flush cycle is discarded even if in_ready=1.
  - out_valid=0 the cycle after flush.
  - A pop in the flush cycle still counts as consumed downstream.
- Reset mid-operation: any held entries are dropped; no partial write-back.
- Widths: no arithmetic; wb_value_out is a pure mux of the head entry.

Optional Feature:
- Macro: WB_PIPE_STATS_EN.
- When defined, two output ports are added:
  - stall_cnt_out (32 bits): +1 every cycle with out_valid & !out_ready; saturates at 0xFFFF_FFFF.
  - xfer_cnt_out (32 bits): +1 per pop; wraps modulo 2^32.
- Both counters clear on rst only; flush does not clear them.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, all *_out=0, in_ready=0 during rst, in_ready=1 the following cycle.
- Streaming: out_ready=1; send ALU_Res=0x10,0x20,0x30 on consecutive cycles with MEM_R_EN=0 -> wb_value_out=0x10,0x20,0x30 one cycle later each; state never FULL.
- Stall and skid:
  - Push A (Dest=3), hold out_ready=0, push B (Dest=5) -> FULL, in_ready=0; outputs stay on A.
  - Raise out_ready -> A then B pop in order; in_ready=1 after the first pop.
- Mem mux: entry MEM_R_EN=1, ALU_Res=0xAAAA, MEM_Result=0x1234 -> wb_value_out=0x1234; with MEM_R_EN=0 -> 0xAAAA.
- Flush while FULL, with a new in_valid entry in the same cycle -> next cycle out_valid=0, WB_EN_out=0; the new entry never appears.
- With WB_PIPE_STATS_EN: 4 stall cycles then 2 pops -> stall_cnt_out=4, xfer_cnt_out=2; a following flush leaves both unchanged.

Source files
------------

// File: rtl/wb_pipe_skid_reg.sv
// MEM->WB pipeline register with a 2-entry skid buffer; in_ready is decoded from state only.
// Optional stall/transfer counters are enabled with `define WB_PIPE_STATS_EN.
module wb_pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic [DATA_W-1:0] ALU_Res,
  input  logic [DATA_W-1:0] MEM_Result,
  input  logic [DEST_W-1:0] Dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic [DATA_W-1:0] ALU_Res_out,
  output logic [DATA_W-1:0] MEM_Result_out,
  output logic [DEST_W-1:0] Dest_out,
  output logic [DATA_W-1:0] wb_value_out
`ifdef WB_PIPE_STATS_EN
  ,
  output logic [31:0]       stall_cnt_out,
  output logic [31:0]       xfer_cnt_out
`endif
);

  // state   | meaning
  // S_EMPTY | nothing held, outputs invalid
  // S_BUSY  | main register holds the head entry
  // S_FULL  | main holds head, skid holds the next entry
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DEST_W-1:0] dest;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   acc;
  logic   pop;

  assign in_entry  = {WB_EN, MEM_R_EN, ALU_Res, MEM_Result, Dest};
  assign in_ready  = (state_q != S_FULL) && !rst;
  assign out_valid = (state_q != S_EMPTY);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Control bits are dropped so nothing stale can write back; data may linger.
      state_d         = S_EMPTY;
      main_d.wb_en    = 1'b0;
      main_d.mem_r_en = 1'b0;
      skid_d.wb_en    = 1'b0;
      skid_d.mem_r_en = 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            state_d = S_BUSY;
            main_d  = in_entry;
          end
        end
        S_BUSY: begin
          if (acc && !pop) begin
            state_d = S_FULL;
            skid_d  = in_entry;
          end else if (acc && pop) begin
            main_d = in_entry;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            state_d = S_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign WB_EN_out      = out_valid && main_q.wb_en;
  assign MEM_R_EN_out   = main_q.mem_r_en;
  assign ALU_Res_out    = main_q.alu;
  assign MEM_Result_out = main_q.mem;
  assign Dest_out       = main_q.dest;
  assign wb_value_out   = main_q.mem_r_en ? main_q.mem : main_q.alu;

`ifdef WB_PIPE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (pop) begin
      xfer_cnt_d = xfer_cnt_q + 32'd1;
    end
  end

  // Only reset clears the counters; a flush is an ordinary pipeline event.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
  assign xfer_cnt_out  = xfer_cnt_q;
`endif

endmodule
